io_sel_sequencer: RTL
=====================

Name: io_sel_sequencer

Overview:
- Register-programmable controller that owns the 15-bit shared-pin select vector driving the SoC pin multiplexer.
- Pin-function changes are applied in a glitch-safe sequence: pins being switched are forced to input (high-Z) for a guard time, the select bits change, and the pins are held high-Z for a further guard time before release.
- Sits between the peripheral register bus and the pin mux. The pad-side wrapper ORs force_hiz into the mux output-enable; en=1 means input.

Parameters:
- NO_OF_SHARED_PINS, 15, width of the select, pending and force_hiz vectors.
- GUARD_CYCLES, 4, length of each high-Z wait phase in clocks. A value of 0 is treated as 1.
- RESET_SEL, 0, value of io_sel after reset.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- reg_we  in  1  register write strobe, single cycle.
- reg_re  in  1  register read strobe, single cycle.
- reg_addr  in  4  byte address: 0x0 PENDING, 0x4 ACTIVE, 0x8 CTRL, 0xC STATUS.
- reg_wdata  in  32  write data.
- reg_rdata  out  32  read data, valid while reg_ack is high.
- reg_ack  out  1  one-cycle acknowledge, asserted the cycle after any we or re.
- io_sel  out  NO_OF_SHARED_PINS  active select vector to the pin mux.
- force_hiz  out  NO_OF_SHARED_PINS  per-pin force-to-input.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse when a sequence completes.

Behaviour:
- Reset values:
  - io_sel = RESET_SEL; PENDING = RESET_SEL.
  - force_hiz, busy, done, reg_ack, reg_rdata = 0.
  - lock = 0, apply_err = 0, state = IDLE.
- Registers:
  - PENDING [14:0] is RW.
  - ACTIVE [14:0] is RO and equals io_sel.
  - CTRL bit0 APPLY is write-1 to start and reads as 0. CTRL bit1 LOCK is write-1 to set; it is sticky until reset, and writing 0 has no effect.
  - STATUS bit0 = busy, bit1 = apply_err (write-1 to clear), bit2 = lock.
  - Unused bits read 0. Reads of unmapped addresses return 0 and are still acknowledged.
- Simultaneous we and re: the write is performed; rdata returns the pre-write value.
- Lock: while lock=1, writes to PENDING and APPLY are ignored (still acknowledged). Setting LOCK mid-sequence does not abort that sequence.
- FSM states: IDLE, HIZ, SWITCH, SETTLE, DONE. G = max(GUARD_CYCLES, 1).
  - IDLE, APPLY write accepted at edge E0:
    - snap <= PENDING; diff <= PENDING ^ io_sel.
    - If diff != 0, go to HIZ, with force_hiz = diff and busy = 1 from E0.
    - If diff == 0, go to DONE.
  - HIZ: counter counts G cycles, then SWITCH at edge E0+G.
  - SWITCH: io_sel <= snap at edge E0+G+1, then SETTLE.
  - SETTLE: G cycles, then DONE at edge E0+2G+1.
  - DONE: one cycle. done = 1, busy = 0, force_hiz = 0, then IDLE.
- Resulting timing for diff != 0: with G=4, io_sel changes at E0+5, busy is high for cycles E0..E0+8, and done is high in the cycle after E0+9. For diff == 0, done is high the cycle after E0 and busy never asserts.
- force_hiz is exactly diff in HIZ, SWITCH and SETTLE, and 0 otherwise. Pins not in diff are never disturbed.
- Busy-time rules:
  - PENDING writes while busy are accepted but do not affect the in-flight sequence; they are used by the next APPLY.
  - APPLY while not IDLE is ignored and sets apply_err.
  - apply_err W1C and a new APPLY error on the same edge: set wins.
- Asynchronous reset mid-sequence: the block returns immediately to the reset values. io_sel = RESET_SEL even if a switch was pending; no done pulse is generated.
- Counter width is $clog2(G+1). The counter is cleared on entry to HIZ and to SETTLE.

Test Plan:
- Reset, then read all four registers: ACTIVE = RESET_SEL (0), STATUS = 0, reg_ack exactly one cycle after each re.
- Write PENDING = 0x0005, then APPLY with G=4:
  - force_hiz = 0x0005 from the apply edge; io_sel = 0x0005 exactly 5 cycles later.
  - Single done pulse at +9; busy high for 9 cycles; other force_hiz bits stay 0 throughout.
- APPLY with PENDING equal to ACTIVE: done pulses the next cycle; busy and force_hiz stay 0.
- During a sequence, write PENDING = 0x7FFF and APPLY:
  - In-flight sequence completes with the old snapshot; STATUS.apply_err = 1.
  - W1C clears it; a second APPLY then drives io_sel to 0x7FFF.
- Set LOCK, write PENDING = 0x0100 and APPLY: PENDING and io_sel are unchanged, STATUS.lock = 1, each access acknowledged.
- Assert rst_n low during SETTLE: io_sel returns to 0 and force_hiz, busy and done are 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/io_sel_sequencer.sv
// Shared-pin select controller: register-programmed, applies pin-function changes
// by forcing affected pins high-Z around the select update.
module io_sel_sequencer #(
    parameter int unsigned                    NO_OF_SHARED_PINS = 15,
    parameter int unsigned                    GUARD_CYCLES      = 4,
    parameter logic [NO_OF_SHARED_PINS-1:0]   RESET_SEL         = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         reg_we,
    input  logic                         reg_re,
    input  logic [3:0]                   reg_addr,
    input  logic [31:0]                  reg_wdata,
    output logic [31:0]                  reg_rdata,
    output logic                         reg_ack,
    output logic [NO_OF_SHARED_PINS-1:0] io_sel,
    output logic [NO_OF_SHARED_PINS-1:0] force_hiz,
    output logic                         busy,
    output logic                         done
);

    localparam int unsigned G  = (GUARD_CYCLES == 0) ? 1 : GUARD_CYCLES;
    localparam int unsigned CW = $clog2(G + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(G - 1);

    localparam logic [3:0] ADDR_PENDING = 4'h0;
    localparam logic [3:0] ADDR_ACTIVE  = 4'h4;
    localparam logic [3:0] ADDR_CTRL    = 4'h8;
    localparam logic [3:0] ADDR_STATUS  = 4'hC;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HIZ,
        ST_SWITCH,
        ST_SETTLE,
        ST_DONE
    } state_t;

    localparam int unsigned N = NO_OF_SHARED_PINS;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   snap_q, snap_d;
    logic [N-1:0]   diff_q, diff_d;
    logic [N-1:0]   io_sel_q, io_sel_d;
    logic [N-1:0]   pending_q, pending_d;
    logic [N-1:0]   force_hiz_q, force_hiz_d;
    logic           lock_q, lock_d;
    logic           apply_err_q, apply_err_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           ack_q, ack_d;
    logic [31:0]    rdata_q, rdata_d;
    logic [31:0]    rd_val;

    logic pending_wr, ctrl_wr, status_wr, apply_req, in_seq_d;
    logic unused_wdata;

    assign unused_wdata = ^reg_wdata[31:N];

    assign pending_wr = reg_we && (reg_addr == ADDR_PENDING);
    assign ctrl_wr    = reg_we && (reg_addr == ADDR_CTRL);
    assign status_wr  = reg_we && (reg_addr == ADDR_STATUS);
    // Lock gates APPLY using its value before this write, so LOCK|APPLY in one write still applies.
    assign apply_req  = ctrl_wr && reg_wdata[0] && !lock_q;

    // Register file: reads always see pre-write state, which gives the we+re ordering for free.
    always_comb begin
        rd_val = '0;
        case (reg_addr)
            ADDR_PENDING: rd_val[N-1:0] = pending_q;
            ADDR_ACTIVE:  rd_val[N-1:0] = io_sel_q;
            ADDR_CTRL:    rd_val[1]     = lock_q;
            ADDR_STATUS:  rd_val[2:0]   = {lock_q, apply_err_q, busy_q};
            default:      rd_val        = '0;
        endcase
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        snap_d      = snap_q;
        diff_d      = diff_q;
        io_sel_d    = io_sel_q;
        pending_d   = pending_q;
        lock_d      = lock_q | (ctrl_wr & reg_wdata[1]);
        apply_err_d = apply_err_q;
        ack_d       = reg_we | reg_re;
        rdata_d     = reg_re ? rd_val : '0;

        if (pending_wr && !lock_q) begin
            pending_d = reg_wdata[N-1:0];
        end
        if (status_wr && reg_wdata[1]) begin
            apply_err_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (apply_req) begin
                    snap_d = pending_q;
                    diff_d = pending_q ^ io_sel_q;
                    cnt_d  = '0;
                    state_d = (|diff_d) ? ST_HIZ : ST_DONE;
                end
            end
            ST_HIZ: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_SWITCH;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_SWITCH: begin
                io_sel_d = snap_q;
                cnt_d    = '0;
                state_d  = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Placed after the W1C so a coincident new error wins.
        if (apply_req && (state_q != ST_IDLE)) begin
            apply_err_d = 1'b1;
        end

        // Pin-facing outputs are registered from the next state so they never glitch.
        in_seq_d    = (state_d == ST_HIZ) || (state_d == ST_SWITCH) || (state_d == ST_SETTLE);
        force_hiz_d = in_seq_d ? diff_d : '0;
        busy_d      = in_seq_d;
        done_d      = (state_d == ST_DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    // NOTE: every register here is control state with a defined reset value; there is no memory array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            snap_q      <= RESET_SEL;
            diff_q      <= '0;
            io_sel_q    <= RESET_SEL;
            pending_q   <= RESET_SEL;
            force_hiz_q <= '0;
            lock_q      <= 1'b0;
            apply_err_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ack_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            snap_q      <= snap_d;
            diff_q      <= diff_d;
            io_sel_q    <= io_sel_d;
            pending_q   <= pending_d;
            force_hiz_q <= force_hiz_d;
            lock_q      <= lock_d;
            apply_err_q <= apply_err_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
        end
    end

    assign io_sel    = io_sel_q;
    assign force_hiz = force_hiz_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign reg_ack   = ack_q;
    assign reg_rdata = rdata_q;

endmodule
